// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK decoder: FSM encoding, dir bit indices,
// packet field positions and the LED command base.
package jstk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_A,
    WAIT_B,
    CHECK,
    DECODE
  } state_t;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam int PKT_W   = 40;
  localparam int X_LO_HI = 39;
  localparam int X_LO_LO = 32;
  localparam int X_HI_HI = 25;
  localparam int X_HI_LO = 24;
  localparam int Y_LO_HI = 23;
  localparam int Y_LO_LO = 16;
  localparam int Y_HI_HI = 9;
  localparam int Y_HI_LO = 8;
  localparam int BTN_T0  = 1;
  localparam int BTN_T1  = 2;

  localparam logic [7:0] CMD_BASE = 8'h80;

  typedef logic [PKT_W-1:0] pkt_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       trig;
  } sample_t;

  // Stick press (bit 0) is deliberately not part of the trigger.
  function automatic sample_t pkt_decode(input pkt_t p);
    sample_t s;
    s.x    = {p[X_HI_HI:X_HI_LO], p[X_LO_HI:X_LO_LO]};
    s.y    = {p[Y_HI_HI:Y_HI_LO], p[Y_LO_HI:Y_LO_LO]};
    s.trig = p[BTN_T0] | p[BTN_T1];
    return s;
  endfunction

endpackage

// File: rtl/jstk_axis_dir.sv
// Combinational dominant-direction decode: offsets from centre, deadzone,
// larger-magnitude axis wins with X taking ties.
module jstk_axis_dir
  import jstk_pkg::*;
#(
  parameter int CENTER   = 512,
  parameter int DEADZONE = 100
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [3:0] dir
);

  logic signed [10:0] dx, dy;
  logic        [10:0] ax, ay;

  assign dx = signed'({1'b0, x} - 11'(CENTER));
  assign dy = signed'({1'b0, y} - 11'(CENTER));
  // |-512| = 512 still fits the unsigned 11-bit magnitude.
  assign ax = dx[10] ? 11'(-dx) : 11'(dx);
  assign ay = dy[10] ? 11'(-dy) : 11'(dy);

  always_comb begin
    dir = '0;
    if (!(ax <= 11'(DEADZONE) && ay <= 11'(DEADZONE))) begin
      if (ax >= ay) begin
        if (dx[10]) dir[DIR_LEFT]  = 1'b1;
        else        dir[DIR_RIGHT] = 1'b1;
      end else begin
        if (dy[10]) dir[DIR_DOWN]  = 1'b1;
        else        dir[DIR_UP]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jstk_decoder.sv
// PmodJSTK poll sequencer, stability-checked capture and decode to X/Y/dir/fire.
// Optional LED feedback on led_cmd under `define JSTK_LED_FEEDBACK_EN.
module jstk_decoder
  import jstk_pkg::*;
#(
  parameter int POLL_PERIOD = 650000,
  parameter int REQ_HOLD    = 2000,
  parameter int SETTLE      = 1000,
  parameter int MAX_RETRY   = 3,
  parameter int CENTER      = 512,
  parameter int DEADZONE    = 100,
  parameter int COOLDOWN    = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] jstk_data,
  output logic        poll,
  output logic [7:0]  led_cmd,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [3:0]  dir,
  output logic        fire,
  output logic        valid,
  output logic        sample_err
);

  localparam int CNT_MAX = (POLL_PERIOD > REQ_HOLD)
                         ? ((POLL_PERIOD > SETTLE) ? POLL_PERIOD : SETTLE)
                         : ((REQ_HOLD > SETTLE) ? REQ_HOLD : SETTLE);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_lim;
  logic              cnt_done;
  pkt_t              sync1, sync2, snap_a, snap_b;
  logic [RTY_W-1:0]  retry;
  logic [CD_W-1:0]   cd, cd_nxt;
  logic              btn_prev, fire_nxt;
  sample_t           smp;
  logic [3:0]        dir_dec;

  // Packet comes from the divided serial-clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= jstk_data;
      sync2 <= sync1;
    end
  end

  assign smp = pkt_decode(snap_b);

  jstk_axis_dir #(
    .CENTER   (CENTER),
    .DEADZONE (DEADZONE)
  ) u_axis_dir (
    .x   (smp.x),
    .y   (smp.y),
    .dir (dir_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_lim   = '0;
    case (state)
      IDLE:   cnt_lim = CNT_W'(POLL_PERIOD - 1);
      REQ:    cnt_lim = CNT_W'(REQ_HOLD - 1);
      WAIT_A: cnt_lim = CNT_W'(SETTLE - 1);
      WAIT_B: cnt_lim = CNT_W'(SETTLE - 1);
      default: cnt_lim = '0;
    endcase
    cnt_done = (cnt == cnt_lim);
    case (state)
      IDLE:   if (cnt_done) state_nxt = REQ;
      REQ:    if (cnt_done) state_nxt = WAIT_A;
      WAIT_A: if (cnt_done) state_nxt = WAIT_B;
      WAIT_B: if (cnt_done) state_nxt = CHECK;
      CHECK: begin
        if (snap_a == snap_b)                 state_nxt = DECODE;
        else if (retry < RTY_W'(MAX_RETRY))   state_nxt = WAIT_A;
        else                                  state_nxt = IDLE;
      end
      DECODE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Held button never re-fires: history updates even when an edge is discarded.
  always_comb begin
    fire_nxt = smp.trig && !btn_prev && (cd == '0);
    if (fire_nxt)        cd_nxt = CD_W'(COOLDOWN);
    else if (cd != '0)   cd_nxt = cd - 1'b1;
    else                 cd_nxt = cd;
  end

  assign poll = (state == REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      snap_a     <= '0;
      snap_b     <= '0;
      retry      <= '0;
      cd         <= '0;
      btn_prev   <= 1'b0;
      x_pos      <= 10'(CENTER);
      y_pos      <= 10'(CENTER);
      dir        <= '0;
      fire       <= 1'b0;
      valid      <= 1'b0;
      sample_err <= 1'b0;
    end else begin
      valid      <= 1'b0;
      fire       <= 1'b0;
      sample_err <= 1'b0;
      cnt        <= (state_nxt != state) ? '0 : cnt + 1'b1;
      case (state)
        WAIT_A: if (cnt_done) snap_a <= sync2;
        WAIT_B: if (cnt_done) snap_b <= sync2;
        CHECK: begin
          if (snap_a == snap_b) begin
            retry <= '0;
          end else if (retry < RTY_W'(MAX_RETRY)) begin
            retry <= retry + 1'b1;
          end else begin
            retry      <= '0;
            sample_err <= 1'b1;
          end
        end
        DECODE: begin
          x_pos    <= smp.x;
          y_pos    <= smp.y;
          dir      <= dir_dec;
          valid    <= 1'b1;
          fire     <= fire_nxt;
          cd       <= cd_nxt;
          btn_prev <= smp.trig;
        end
        default: ;
      endcase
    end
  end

`ifdef JSTK_LED_FEEDBACK_EN
  // LED2 mirrors the trigger, LED1 lit while the fire cooldown runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  led_cmd <= CMD_BASE;
    else if (state == DECODE) led_cmd <= {CMD_BASE[7:2], smp.trig, cd_nxt != '0};
  end
`else
  assign led_cmd = CMD_BASE;
`endif

endmodule

// File: tb/tb_jstk_decoder.sv
// Scoreboard bench for jstk_decoder: directed packets, expected responses queued
// by the stimulus and checked by a monitor whenever valid/sample_err/fire appear.
module tb_jstk_decoder;

  localparam int PP = 30;
  localparam int RH = 4;
  localparam int ST = 5;
  localparam int MR = 3;
  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [39:0] jstk_data = '0;
  logic        poll, fire, valid, sample_err;
  logic [7:0]  led_cmd;
  logic [9:0]  x_pos, y_pos;
  logic [3:0]  dir;

  always #5 clk = ~clk;

  jstk_decoder #(
    .POLL_PERIOD (PP),
    .REQ_HOLD    (RH),
    .SETTLE      (ST),
    .MAX_RETRY   (MR),
    .CENTER      (512),
    .DEADZONE    (100),
    .COOLDOWN    (CD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .jstk_data  (jstk_data),
    .poll       (poll),
    .led_cmd    (led_cmd),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .dir        (dir),
    .fire       (fire),
    .valid      (valid),
    .sample_err (sample_err)
  );

  typedef struct {
    logic       err;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] dir;
    logic       fire;
    logic [7:0] led;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_miss = 0;
  logic [9:0] last_x = 10'd512;
  logic [9:0] last_y = 10'd512;
  logic [3:0] last_dir = 4'b0000;
  logic [7:0] last_led = 8'h80;

  function automatic logic [39:0] pkt(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
    return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
  endfunction

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (valid || sample_err || fire)) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_output: valid=%0b sample_err=%0b fire=%0b, want none",
                   valid, sample_err, fire);
        end else begin
          e = sb.pop_front();
          chk("kind{valid,err}", {valid, sample_err}, e.err ? 2'b01 : 2'b10);
          chk("x_pos", x_pos, e.x);
          chk("y_pos", y_pos, e.y);
          chk("dir", dir, e.dir);
          chk("fire", fire, e.fire);
          chk("led_cmd", led_cmd, e.led);
        end
      end
    end
  endtask

  task automatic wait_poll(input logic lvl);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (poll !== lvl && n < 500);
    if (poll !== lvl) chk("poll_timeout", poll, lvl);
  endtask

  task automatic push_valid(input logic [9:0] x, input logic [9:0] y, input logic [3:0] d,
                            input logic f, input logic [7:0] led);
    sb.push_back('{1'b0, x, y, d, f, led});
    last_x = x; last_y = y; last_dir = d; last_led = led;
  endtask

  function automatic logic [7:0] led_of(input logic trig, input logic lit);
    logic [7:0] l;
`ifdef JSTK_LED_FEEDBACK_EN
    l = {6'b100000, trig, lit};
`else
    l = 8'h80 | {7'b0, trig & lit & 1'b0};
`endif
    return l;
  endfunction

  // One clean poll with a stable packet.
  task automatic stable(input logic [9:0] x, input logic [9:0] y, input logic [2:0] btn,
                        input logic [3:0] d, input logic f, input logic lit);
    @(negedge clk);
    jstk_data = pkt(x, y, btn);
    push_valid(x, y, d, f, led_of(btn[1] | btn[2], lit));
    wait_poll(1'b1);
    wait_poll(1'b0);
    repeat (2 * ST + 4) @(negedge clk);
  endtask

  // Every snapshot pair differs; poll must be dropped with outputs kept.
  task automatic drop_poll();
    int n = 0;
    sb.push_back('{1'b1, last_x, last_y, last_dir, 1'b0, last_led});
    wait_poll(1'b1);
    wait_poll(1'b0);
    do begin
      @(negedge clk);
      jstk_data = n[0] ? pkt(10'd700, 10'd300, 3'd0) : pkt(10'd300, 10'd700, 3'd0);
      n++;
    end while (poll !== 1'b1 && n < 500);
    if (poll !== 1'b1) chk("drop_timeout", poll, 1'b1);
    jstk_data = pkt(10'd512, 10'd512, 3'd0);
    push_valid(10'd512, 10'd512, 4'b0000, 1'b0, led_of(1'b0, 1'b0));
    wait_poll(1'b0);
    repeat (2 * ST + 4) @(negedge clk);
  endtask

  // First attempt mismatches, retry sees a stable packet.
  task automatic glitch_once();
    logic [39:0] po, pf;
    po = pkt(10'd900, 10'd900, 3'd0);
    pf = pkt(10'd300, 10'd600, 3'd0);
    @(negedge clk);
    jstk_data = po;
    push_valid(10'd300, 10'd600, 4'b0010, 1'b0, led_of(1'b0, 1'b0));
    wait_poll(1'b1);
    wait_poll(1'b0);
    for (int i = 0; i < 2 * ST; i++) begin
      @(negedge clk);
      jstk_data = i[0] ? pf : po;
    end
    @(negedge clk);
    jstk_data = pf;
    repeat (4 * ST + 4) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_poll"}, poll, 1'b0);
    chk({tag, "_x"}, x_pos, 10'd512);
    chk({tag, "_y"}, y_pos, 10'd512);
    chk({tag, "_dir"}, dir, 4'b0000);
    chk({tag, "_flags"}, {fire, valid, sample_err}, 3'b000);
    chk({tag, "_led"}, led_cmd, 8'h80);
  endtask

  initial begin
    int cyc;
    fork
      monitor();
    join_none

    rst = 1'b1;
    jstk_data = pkt(10'd512, 10'd512, 3'd0);
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    push_valid(10'd512, 10'd512, 4'b0000, 1'b0, led_of(1'b0, 1'b0));

    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!poll && cyc < 500);
    chk("poll_low_cycles", cyc, PP);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (poll && cyc < 500);
    chk("poll_high_cycles", cyc, RH);
    repeat (2 * ST + 4) @(negedge clk);

    // x, y, btn, dir, fire, cooldown-active-after
    stable(10'd900, 10'd700,  3'd0, 4'b0001, 1'b0, 1'b0);
    stable(10'd612, 10'd412,  3'd0, 4'b0000, 1'b0, 1'b0);
    stable(10'd800, 10'd224,  3'd0, 4'b0001, 1'b0, 1'b0);
    stable(10'd512, 10'd0,    3'd0, 4'b0100, 1'b0, 1'b0);
    stable(10'd100, 10'd512,  3'd0, 4'b0010, 1'b0, 1'b0);
    stable(10'd512, 10'd1023, 3'd0, 4'b1000, 1'b0, 1'b0);

    drop_poll();
    glitch_once();

    stable(10'd512, 10'd512, 3'd2, 4'b0000, 1'b1, 1'b1); // fire, cd=4
    stable(10'd512, 10'd512, 3'd0, 4'b0000, 1'b0, 1'b1); // cd=3
    stable(10'd512, 10'd512, 3'd2, 4'b0000, 1'b0, 1'b1); // edge discarded, cd=2
    stable(10'd512, 10'd512, 3'd0, 4'b0000, 1'b0, 1'b1); // cd=1
    stable(10'd512, 10'd512, 3'd0, 4'b0000, 1'b0, 1'b0); // cd=0
    stable(10'd512, 10'd512, 3'd4, 4'b0000, 1'b1, 1'b1); // fire via bit 2
    for (int i = 0; i < 5; i++)
      stable(10'd512, 10'd512, 3'd4, 4'b0000, 1'b0, (i < 3)); // held: no re-fire
    stable(10'd512, 10'd512, 3'd1, 4'b0000, 1'b0, 1'b0); // stick press ignored
    stable(10'd512, 10'd512, 3'd2, 4'b0000, 1'b1, 1'b1);

    wait_poll(1'b1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stable(10'd900, 10'd700, 3'd0, 4'b0001, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
